// File: rtl/fifo_to_axis_pkg.sv
// Shared definitions for the FIFO-to-AXIS unpacker: lane geometry, words per beat,
// FSM state encoding and the position of the byte length inside tuser.
package fifo_to_axis_pkg;

    localparam int LANE_W         = 9;
    localparam int AXIS_DATA_W    = 256;
    localparam int AXIS_TUSER_W   = 128;
    localparam int FIFO_W         = 72;
    localparam int WORDS_PER_BEAT = AXIS_DATA_W * LANE_W / 8 / FIFO_W;

    localparam int LEN_LSB = 0;
    localparam int LEN_MSB = 15;
    localparam int LEN_W   = LEN_MSB - LEN_LSB + 1;

    typedef enum logic {
        ST_HDR  = 1'b0,
        ST_DATA = 1'b1
    } state_e;

endpackage

// File: rtl/fifo_word_gather.sv
// Collects WORDS consecutive FIFO words (LSW first) into one packed beat; beat_done_o
// marks the cycle the final word is popped, with the full beat presented combinationally.
module fifo_word_gather
    import fifo_to_axis_pkg::*;
#(
    parameter int WORD_W = FIFO_W,
    parameter int WORDS  = WORDS_PER_BEAT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      pop_i,
    input  logic [WORD_W-1:0]         word_i,
    output logic                      last_word_o,
    output logic                      beat_done_o,
    output logic [WORD_W*WORDS-1:0]   beat_o
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int SH_W  = WORD_W * (WORDS - 1);

    logic [IDX_W-1:0] word_idx_q, word_idx_d;
    logic [SH_W-1:0]  shift_q;

    assign last_word_o = (word_idx_q == IDX_W'(WORDS - 1));
    assign beat_done_o = pop_i && last_word_o;
    assign beat_o      = {word_i, shift_q};

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        word_idx_d = word_idx_q;
        if (clr) begin
            word_idx_d = '0;
        end else if (pop_i) begin
            word_idx_d = last_word_o ? '0 : word_idx_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_idx_q <= '0;
        end else begin
            word_idx_q <= word_idx_d;
        end
    end

    // NOTE: the shift register is pure datapath and is left unreset; word_idx_q decides validity.
    always_ff @(posedge clk) begin
        if (pop_i && !last_word_o) begin
            shift_q <= {word_i, shift_q[SH_W-1:WORD_W]};
        end
    end

endmodule

// File: rtl/fifo_to_axis.sv
// Pops packed 9-bit-lane words from a FWFT FIFO and rebuilds AXIS packets (header beat carries tuser).
// Optional length/strobe checker enabled by defining FIFO_TO_AXIS_LEN_CHECK_EN.
module fifo_to_axis
    import fifo_to_axis_pkg::*;
#(
    parameter int C_M_AXIS_DATA_WIDTH  = AXIS_DATA_W,
    parameter int C_M_AXIS_TUSER_WIDTH = AXIS_TUSER_W,
    parameter int FIFO_DATA_WIDTH      = FIFO_W
) (
    input  logic                                axi_aclk,
    input  logic                                axi_resetn,
    input  logic                                sw_rst,
    input  logic [FIFO_DATA_WIDTH-1:0]          fifo_dout,
    input  logic                                fifo_empty,
    output logic                                fifo_rd_en,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic                                m_axis_tlast,
    output logic                                len_err
);

    localparam int STRB_W = C_M_AXIS_DATA_WIDTH / 8;
    localparam int BEAT_W = STRB_W * LANE_W;
    localparam int WORDS  = BEAT_W / FIFO_DATA_WIDTH;
    localparam logic [LEN_W-1:0] BEAT_BYTES = LEN_W'(STRB_W);

    state_e                            state_q, state_d;
    logic [LEN_W-1:0]                  rem_q, rem_d;
    logic [C_M_AXIS_TUSER_WIDTH-1:0]   hdr_tuser_q, hdr_tuser_d;
    logic [C_M_AXIS_DATA_WIDTH-1:0]    tdata_q, tdata_d;
    logic [STRB_W-1:0]                 tstrb_q, tstrb_d;
    logic [C_M_AXIS_TUSER_WIDTH-1:0]   tuser_q, tuser_d;
    logic                              tvalid_q, tvalid_d;
    logic                              tlast_q, tlast_d;

    logic                              last_word, beat_done, out_free, beat_last;
    logic [BEAT_W-1:0]                 beat_packed;
    logic [C_M_AXIS_DATA_WIDTH-1:0]    beat_tdata;
    logic [STRB_W-1:0]                 beat_tstrb;
    logic [LEN_W-1:0]                  hdr_len;

    fifo_word_gather #(
        .WORD_W (FIFO_DATA_WIDTH),
        .WORDS  (WORDS)
    ) u_gather (
        .clk         (axi_aclk),
        .rst_n       (axi_resetn),
        .clr         (sw_rst),
        .pop_i       (fifo_rd_en),
        .word_i      (fifo_dout),
        .last_word_o (last_word),
        .beat_done_o (beat_done),
        .beat_o      (beat_packed)
    );

    // The final word of a data beat waits until the output register can take it.
    assign out_free   = !tvalid_q || m_axis_tready;
    assign fifo_rd_en = axi_resetn && !sw_rst && !fifo_empty &&
                        (!last_word || state_q == ST_HDR || out_free);

    always_comb begin
        for (int i = 0; i < STRB_W; i++) begin
            beat_tdata[8*i +: 8] = beat_packed[LANE_W*i +: 8];
            beat_tstrb[i]        = beat_packed[LANE_W*i + 8];
        end
    end

    assign hdr_len   = beat_tdata[LEN_MSB:LEN_LSB];
    assign beat_last = (rem_q <= BEAT_BYTES);

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        hdr_tuser_d = hdr_tuser_q;
        tdata_d     = tdata_q;
        tstrb_d     = tstrb_q;
        tuser_d     = tuser_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;

        if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
        end

        if (beat_done) begin
            case (state_q)
                ST_HDR: begin
                    hdr_tuser_d = beat_tdata[C_M_AXIS_TUSER_WIDTH-1:0];
                    rem_d       = (hdr_len == '0) ? BEAT_BYTES : hdr_len;
                    state_d     = ST_DATA;
                end
                ST_DATA: begin
                    // tuser comes from the header register so a newer header cannot alter a pending beat.
                    tdata_d  = beat_tdata;
                    tstrb_d  = beat_tstrb;
                    tuser_d  = hdr_tuser_q;
                    tvalid_d = 1'b1;
                    tlast_d  = beat_last;
                    rem_d    = (rem_q > BEAT_BYTES) ? rem_q - BEAT_BYTES : '0;
                    if (beat_last) begin
                        state_d = ST_HDR;
                    end
                end
                default: state_d = ST_HDR;
            endcase
        end

        if (sw_rst) begin
            state_d     = ST_HDR;
            rem_d       = '0;
            hdr_tuser_d = '0;
            tdata_d     = '0;
            tstrb_d     = '0;
            tuser_d     = '0;
            tvalid_d    = 1'b0;
            tlast_d     = 1'b0;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q     <= ST_HDR;
            rem_q       <= '0;
            hdr_tuser_q <= '0;
            tdata_q     <= '0;
            tstrb_q     <= '0;
            tuser_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            hdr_tuser_q <= hdr_tuser_d;
            tdata_q     <= tdata_d;
            tstrb_q     <= tstrb_d;
            tuser_q     <= tuser_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tstrb  = tstrb_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;

`ifdef FIFO_TO_AXIS_LEN_CHECK_EN
    logic              len_zero_q, len_zero_d;
    logic              len_err_q, len_err_d;
    logic [STRB_W-1:0] exp_strb;

    // On the last beat rem_q holds the residual byte count (1..STRB_W); earlier beats must be full.
    always_comb begin
        for (int i = 0; i < STRB_W; i++) begin
            exp_strb[i] = beat_last ? (LEN_W'(i) < rem_q) : 1'b1;
        end
    end

    always_comb begin
        len_zero_d = len_zero_q;
        len_err_d  = 1'b0;
        if (beat_done && state_q == ST_HDR) begin
            len_zero_d = (hdr_len == '0);
        end
        if (beat_done && state_q == ST_DATA) begin
            len_err_d = len_zero_q || (beat_tstrb != exp_strb);
        end
        if (sw_rst) begin
            len_zero_d = 1'b0;
            len_err_d  = 1'b0;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            len_zero_q <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            len_zero_q <= len_zero_d;
            len_err_q  <= len_err_d;
        end
    end

    assign len_err = len_err_q;
`else
    assign len_err = 1'b0;
`endif

endmodule
